sqrt_rr_scheduler: RTL and testbench

Shares one instance of the existing combinational square_root datapath (8-bit integer in, 16-bit unsigned 8.8 fixed-point out) among N_REQ requesters, such as the weight and dimension checkers at the drop station.
- Arbitrates round-robin and registers the operand in front of the datapath.
- Registers the result behind the datapath, breaking the long combinational path.
- Returns each result with the ID of its requester over a valid/ready handshake.

---
 rtl/sqrt_sched_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/square_root.sv | 33 +++
 rtl/sqrt_rr_scheduler.sv | 99 +++++++++
 tb/tb_sqrt_rr_scheduler.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/sqrt_sched_pkg.sv
// Shared types and constants for the square-root request scheduler.
// Operand/result widths are fixed by the square_root datapath.
package sqrt_sched_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Pure combinational round-robin search: first set bit of req at or above
// ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any_req
);

  logic         found;
  logic [W-1:0] pos;

  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = '0;
    any_req = |req;
    for (int k = 0; k < N; k++) begin
      pos = W'((int'(ptr) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/square_root.sv
// Combinational square root: integer operand in, unsigned 8.8 result out,
// truncated (floor of sqrt(op * 2^16)).
module square_root
  import sqrt_sched_pkg::*;
(
  input  logic [IN_W-1:0]  op,
  output logic [OUT_W-1:0] root
);

  localparam int FRAC  = OUT_W - IN_W;
  localparam int RAD_W = IN_W + 2 * FRAC;
  localparam int ACC_W = RAD_W / 2;

  logic [RAD_W-1:0] rad;
  logic [RAD_W-1:0] sq;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] trial;

  always_comb begin
    rad   = {op, {(2 * FRAC){1'b0}}};
    acc   = '0;
    trial = '0;
    sq    = '0;
    // Restoring bit-by-bit search, MSB first.
    for (int b = ACC_W - 1; b >= 0; b--) begin
      trial = acc | (ACC_W'(1) << b);
      sq    = RAD_W'(trial) * RAD_W'(trial);
      if (sq <= rad) acc = trial;
    end
    root = OUT_W'(acc);
  end

endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Shares one square_root datapath among N_REQ requesters with round-robin
// arbitration, registered operand/result and a valid/ready result port.
//
// state | meaning
// IDLE  | waiting for a request; grant is live, accept on the edge
// CALC  | op_reg drives square_root; result captured on the edge
// HOLD  | result presented on res_*; leaves when res_ready is high
module sqrt_rr_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*IN_W-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  res_valid,
  output logic [ID_W-1:0]       res_id,
  output logic [OUT_W-1:0]      res_data,
  input  logic                  res_ready,
  output logic                  busy
);

  state_t            state, state_nxt;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   pick_idx;
  logic              any_req;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   next_ptr;
  logic [ID_W-1:0]   id_reg;
  logic [IN_W-1:0]   op_reg;
  logic [OUT_W-1:0]  root;

  rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  square_root u_sqrt (
    .op   (op_reg),
    .root (root)
  );

  assign next_ptr = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (any_req) state_nxt = CALC;
      end
      CALC:    state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      id_reg    <= '0;
      op_reg    <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_reg <= req_data[int'(pick_idx) * IN_W +: IN_W];
            id_reg <= pick_idx;
            rr_ptr <= next_ptr;
          end
        end
        CALC: begin
          res_data  <= root;
          res_id    <= id_reg;
          res_valid <= 1'b1;
        end
        HOLD: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Directed bench for sqrt_rr_scheduler with hand-computed expected results.
module tb_sqrt_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [15:0] res_data;
  logic        res_ready;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  sqrt_rr_scheduler #(.N_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request through IDLE -> CALC -> HOLD -> IDLE with res_ready high.
  task automatic txn(input string tag, input logic [3:0] mask, input logic [31:0] data,
                     input logic [1:0] want_id, input logic [15:0] want_data);
    logic [3:0] want_ready;
    want_ready = 4'b0001 << want_id;
    req_valid = mask;
    req_data  = data;
    #1;
    chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, want_ready});
    step();
    req_valid = 4'b0000;
    chk({tag, "_calc_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_calc_noval"}, {31'd0, res_valid}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, res_id}, {30'd0, want_id});
    chk({tag, "_data"}, {16'd0, res_data}, {16'd0, want_data});
    step();
    chk({tag, "_done"}, {31'd0, res_valid}, 32'd0);
  endtask

  logic [15:0] fair_exp [4];

  initial begin
    fair_exp[0] = 16'h0100;
    fair_exp[1] = 16'h0200;
    fair_exp[2] = 16'h0300;
    fair_exp[3] = 16'h0500;

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'd0;
    res_ready = 1'b1;
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_id", {30'd0, res_id}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Single request, then precision corners (ptr moves 1 -> 3 -> 0 -> 2).
    txn("single16", 4'b0001, {8'd0, 8'd0, 8'd0, 8'd16}, 2'd0, 16'h0400);
    txn("op2", 4'b0100, {8'd0, 8'd2, 8'd0, 8'd0}, 2'd2, 16'h016A);
    txn("op255", 4'b1000, {8'd255, 8'd0, 8'd0, 8'd0}, 2'd3, 16'h0FF7);
    txn("op0", 4'b0010, {8'd0, 8'd0, 8'd0, 8'd0}, 2'd1, 16'h0000);

    // Pointer wrap: after ID3, ID0 wins over ID3; then ID3 wins from ptr 1.
    txn("wrap_id3", 4'b1000, {8'd100, 8'd0, 8'd0, 8'd0}, 2'd3, 16'h0A00);
    txn("wrap_id0", 4'b1001, {8'd36, 8'd0, 8'd0, 8'd81}, 2'd0, 16'h0900);
    txn("wrap_id3b", 4'b1001, {8'd36, 8'd0, 8'd0, 8'd81}, 2'd3, 16'h0600);

    // Fairness: all valid continuously, ptr starts at 0.
    req_valid = 4'b1111;
    req_data  = {8'd25, 8'd9, 8'd4, 8'd1};
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("fair_ready", {28'd0, req_ready}, 32'd1 << (i % 4));
      step();
      chk("fair_calc_ready", {28'd0, req_ready}, 32'd0);
      step();
      chk("fair_valid", {31'd0, res_valid}, 32'd1);
      chk("fair_id", {30'd0, res_id}, i % 4);
      chk("fair_data", {16'd0, res_data}, {16'd0, fair_exp[i % 4]});
      step();
    end
    req_valid = 4'b0000;
    chk("fair_end_idle", {31'd0, busy}, 32'd0);

    // Backpressure: ptr at 1, hold result for 10 cycles with a pending request.
    req_valid = 4'b0010;
    req_data  = {8'd0, 8'd144, 8'd64, 8'd0};
    res_ready = 1'b0;
    step();
    req_valid = 4'b0000;
    step();
    chk("bp_valid", {31'd0, res_valid}, 32'd1);
    req_valid = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_hold_data", {16'd0, res_data}, 32'h0800);
      chk("bp_hold_id", {30'd0, res_id}, 32'd1);
      chk("bp_hold_ready", {28'd0, req_ready}, 32'd0);
      chk("bp_hold_busy", {31'd0, busy}, 32'd1);
    end
    res_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, res_valid}, 32'd0);
    chk("bp_next_ready", {28'd0, req_ready}, 32'b0100);
    step();
    req_valid = 4'b0000;
    step();
    chk("bp_next_id", {30'd0, res_id}, 32'd2);
    chk("bp_next_data", {16'd0, res_data}, 32'h0C00);
    step();

    // Async reset mid-CALC with ptr at 3 after an ID2 grant.
    req_valid = 4'b0100;
    req_data  = {8'd0, 8'd200, 8'd0, 8'd49};
    step();
    req_valid = 4'b0000;
    chk("ar_in_calc", {31'd0, busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_busy_clear", {31'd0, busy}, 32'd0);
    chk("ar_valid_clear", {31'd0, res_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ar_no_replay", {31'd0, res_valid}, 32'd0);
    end
    txn("ar_restart", 4'b1001, {8'd9, 8'd0, 8'd0, 8'd49}, 2'd0, 16'h0700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
